// File: rtl/memory_unit.sv
// memory_unit: load/store front end for a synchronous word RAM plus a small MMIO
// register file (LED / seven-segment control word, free-running timer, compare).
// Requests are taken with a memReady/memExecute handshake; alignment and
// unmapped-address faults are answered in the accept cycle without leaving IDLE.
module memory_unit #(
    parameter int unsigned RAM_SIZE   = 32768,
    parameter logic [31:0] MMIO_BASE  = 32'h0001_0000,
    parameter int unsigned NUM_LEDS   = 1,
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  resetN,
    output logic                  memReady,
    output logic                  dataReady,
    output logic                  memFault,
    input  logic                  memExecute,
    input  logic                  memWrite,
    input  logic [1:0]            memSize,
    input  logic                  memSign,
    input  logic [31:0]           memAddress,
    input  logic [31:0]           inputData,
    output logic [31:0]           outputData,
    output logic [NUM_LEDS-1:0]   leds,
    output logic [7:0]            sevenSeg,
    output logic [NUM_DIGITS-1:0] sevenSegEn,
    output logic                  timerIrq
);

    localparam int unsigned AW    = $clog2(RAM_SIZE);
    localparam int unsigned DEPTH = RAM_SIZE / 4;
    localparam int unsigned IW    = (AW > 2) ? (AW - 2) : 1;
    localparam int unsigned CW    = NUM_LEDS + 8 + NUM_DIGITS;

    localparam logic [32:0] RAM_LIMIT = 33'(RAM_SIZE);
    localparam logic [32:0] MMIO_LO   = {1'b0, MMIO_BASE};
    localparam logic [32:0] MMIO_HI   = {1'b0, MMIO_BASE} + 33'd8;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IDLE = 3'd1,
        S_RD   = 3'd2,
        S_WR   = 3'd3,
        S_MMIO = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Request latched at accept
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_sign;
    logic        r_write;
    logic [31:0] r_wdata;

    // Response registers
    logic [31:0] r_data_out;
    logic        r_data_ready;
    logic        r_fault;
    logic        r_mem_ready;

    // MMIO registers
    logic [CW-1:0] r_ctrl;
    logic [31:0]   r_counter;
    logic [31:0]   r_compare;
    logic          r_irq;

    // RAM array and its registered read port
    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_ram_q;

    logic          w_accept;
    logic          w_in_ram;
    logic          w_in_mmio;
    logic          w_misalign;
    logic          w_fault;
    logic          w_ram_re;
    logic          w_ram_we;
    logic [IW-1:0] w_rd_idx;
    logic [IW-1:0] w_wr_idx;
    logic          w_sel_ctrl;
    logic          w_sel_cnt;
    logic          w_sel_cmp;
    logic          w_mmio_we;
    logic [31:0]   w_mmio_rdata;

    // Pick the addressed byte or half out of a RAM word and extend it.
    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [1:0]  size,
                                                 input logic        sign);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = 8'(word >> {off, 3'b000});
        h = 16'(word >> {off[1], 4'b0000});
        case (size)
            SZ_BYTE: res = {{24{sign & b[7]}}, b};
            SZ_HALF: res = {{16{sign & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace the store lanes of an existing RAM word with right-aligned store data.
    function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                                input logic [31:0] data,
                                                input logic [1:0]  off,
                                                input logic [1:0]  size);
        logic [31:0] mask;
        logic [31:0] lanes;
        logic [31:0] res;
        case (size)
            SZ_BYTE: begin
                mask  = 32'h0000_00FF << {off, 3'b000};
                lanes = {24'd0, data[7:0]} << {off, 3'b000};
                res   = (old_word & ~mask) | lanes;
            end
            SZ_HALF: begin
                mask  = 32'h0000_FFFF << {off[1], 4'b0000};
                lanes = {16'd0, data[15:0]} << {off[1], 4'b0000};
                res   = (old_word & ~mask) | lanes;
            end
            default: begin
                mask  = 32'hFFFF_FFFF;
                lanes = data;
                res   = data;
            end
        endcase
        return res;
    endfunction

    assign w_accept  = (r_state == S_IDLE) && memExecute;
    assign w_in_ram  = ({1'b0, memAddress} < RAM_LIMIT);
    assign w_in_mmio = ({1'b0, memAddress} >= MMIO_LO) && ({1'b0, memAddress} <= MMIO_HI);
    assign w_rd_idx  = IW'(memAddress >> 2);
    assign w_wr_idx  = IW'(r_addr >> 2);

    // Alignment / size legality of the incoming request
    always_comb begin
        w_misalign = 1'b0;
        case (memSize)
            SZ_BYTE: w_misalign = 1'b0;
            SZ_HALF: w_misalign = memAddress[0];
            SZ_WORD: w_misalign = (memAddress[1:0] != 2'b00);
            default: w_misalign = 1'b1;
        endcase
    end

    assign w_fault = w_misalign
                   || (w_in_mmio && (memSize != SZ_WORD))
                   || (!w_in_ram && !w_in_mmio);

    // The RAM is read at accept for loads and for sub-word stores (read-modify-write)
    assign w_ram_re = w_accept && !w_fault && w_in_ram
                   && (!memWrite || (memSize != SZ_WORD));
    // r_state is forced to INIT asynchronously, so a reset during WR cancels the write
    assign w_ram_we = (r_state == S_WR);

    assign w_sel_ctrl = (r_addr == MMIO_BASE);
    assign w_sel_cnt  = (r_addr == (MMIO_BASE + 32'd4));
    assign w_sel_cmp  = (r_addr == (MMIO_BASE + 32'd8));
    assign w_mmio_we  = (r_state == S_MMIO) && r_write;

    // MMIO read multiplexer
    always_comb begin
        w_mmio_rdata = 32'd0;
        if (w_sel_ctrl) begin
            w_mmio_rdata = 32'(r_ctrl);
        end else if (w_sel_cnt) begin
            w_mmio_rdata = r_counter;
        end else begin
            w_mmio_rdata = r_compare;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_INIT: w_state_next = S_IDLE;
            S_IDLE: begin
                if (w_accept && !w_fault) begin
                    if (w_in_mmio) begin
                        w_state_next = S_MMIO;
                    end else if (memWrite && (memSize == SZ_WORD)) begin
                        w_state_next = S_WR;
                    end else begin
                        w_state_next = S_RD;
                    end
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RD: begin
                if (r_write) begin
                    w_state_next = S_WR;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_WR:    w_state_next = S_IDLE;
            S_MMIO:  w_state_next = S_IDLE;
            default: w_state_next = S_INIT;
        endcase
    end

    // State register; memReady is registered from the next state so it is high exactly in IDLE
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= S_INIT;
            r_mem_ready <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_mem_ready <= (w_state_next == S_IDLE);
        end
    end

    // Request capture, fault response, load result and store-merge datapath
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_addr       <= 32'd0;
            r_size       <= 2'b00;
            r_sign       <= 1'b0;
            r_write      <= 1'b0;
            r_wdata      <= 32'd0;
            r_data_out   <= 32'd0;
            r_data_ready <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr       <= memAddress;
                        r_size       <= memSize;
                        r_sign       <= memSign;
                        r_write      <= memWrite;
                        r_wdata      <= inputData;
                        r_fault      <= w_fault;
                        r_data_ready <= w_fault && !memWrite;
                        if (w_fault) begin
                            r_data_out <= 32'd0;
                        end
                    end
                end
                S_RD: begin
                    if (r_write) begin
                        r_wdata <= merge_store(r_ram_q, r_wdata, r_addr[1:0], r_size);
                    end else begin
                        r_data_out   <= extract_load(r_ram_q, r_addr[1:0], r_size, r_sign);
                        r_data_ready <= 1'b1;
                    end
                end
                S_MMIO: begin
                    if (!r_write) begin
                        r_data_out   <= w_mmio_rdata;
                        r_data_ready <= 1'b1;
                    end
                end
                default: begin
                    r_data_ready <= r_data_ready;
                end
            endcase
        end
    end

    // MMIO registers: display control word, free-running counter (write wins), compare, irq
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_ctrl    <= {CW{1'b0}};
            r_counter <= 32'd0;
            r_compare <= 32'hFFFF_FFFF;
            r_irq     <= 1'b0;
        end else begin
            if (w_mmio_we && w_sel_ctrl) begin
                r_ctrl <= r_wdata[CW-1:0];
            end
            if (w_mmio_we && w_sel_cnt) begin
                r_counter <= r_wdata;
            end else begin
                r_counter <= r_counter + 32'd1;
            end
            if (w_mmio_we && w_sel_cmp) begin
                r_compare <= r_wdata;
            end
            r_irq <= (r_counter >= r_compare);
        end
    end

    // Synchronous word RAM: one write port driven from WR, one registered read port
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_mem[w_wr_idx] <= r_wdata;
        end
        if (w_ram_re) begin
            r_ram_q <= r_mem[w_rd_idx];
        end
    end

    assign memReady   = r_mem_ready;
    assign dataReady  = r_data_ready;
    assign memFault   = r_fault;
    assign outputData = r_data_out;
    assign leds       = r_ctrl[NUM_LEDS-1:0];
    assign sevenSeg   = r_ctrl[NUM_LEDS +: 8];
    assign sevenSegEn = r_ctrl[NUM_LEDS + 8 +: NUM_DIGITS];
    assign timerIrq   = r_irq;

endmodule

// File: tb/tb_memory_unit.sv
// Self-checking bench for memory_unit: directed vector table, timer and
// reset corner sequences, then randomized traffic against a byte-level model.
module tb_memory_unit;

    localparam int unsigned RAM_SIZE = 32768;
    localparam logic [31:0] MB       = 32'h0001_0000;
    localparam logic [1:0]  B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

    logic        clk = 1'b0;
    logic        resetN;
    logic        memReady, dataReady, memFault;
    logic        memExecute, memWrite, memSign;
    logic [1:0]  memSize;
    logic [31:0] memAddress, inputData, outputData;
    logic [0:0]  leds;
    logic [7:0]  sevenSeg;
    logic [3:0]  sevenSegEn;
    logic        timerIrq;

    always #5 clk = ~clk;

    memory_unit #(.RAM_SIZE(RAM_SIZE), .MMIO_BASE(MB), .NUM_LEDS(1), .NUM_DIGITS(4)) dut (
        .clk(clk), .resetN(resetN), .memReady(memReady), .dataReady(dataReady),
        .memFault(memFault), .memExecute(memExecute), .memWrite(memWrite),
        .memSize(memSize), .memSign(memSign), .memAddress(memAddress),
        .inputData(inputData), .outputData(outputData), .leds(leds),
        .sevenSeg(sevenSeg), .sevenSegEn(sevenSegEn), .timerIrq(timerIrq)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] data;
        logic        chk_data;
        logic [31:0] exp_data;
        logic        exp_flt;
        logic        exp_dr;
        int          exp_lat;
    } vec_t;

    localparam int NV = 19;
    vec_t vt [NV];

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] ref_mem [256];

    task automatic check(input string what, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", what, got, exp);
        end
    endtask

    // One handshake: wait for memReady, strobe for one edge, wait for memReady again.
    task automatic do_op(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] data,
                         output logic [31:0] rdata, output logic flt,
                         output logic drdy, output int lat);
        int guard;
        guard = 0;
        while (memReady !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (memReady !== 1'b1) begin
            n_vec++;
            n_bad++;
            $display("FAIL ready-timeout: memReady=%b before request to %08h", memReady, addr);
        end
        memExecute = 1'b1;
        memWrite   = wr;
        memSize    = sz;
        memSign    = sg;
        memAddress = addr;
        inputData  = data;
        @(negedge clk);
        memExecute = 1'b0;
        lat = 0;
        while (memReady !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rdata = outputData;
        flt   = memFault;
        drdy  = dataReady;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, ra, rdt, ev;
        logic        fl, dr, wr, sg, oor, ef;
        logic [1:0]  sz;
        int          lat, n, nb, el;

        vt[0]  = '{1'b1, W, 1'b0, 32'h10, 32'h1122_3344, 1'b0, 32'h0, 1'b0, 1'b0, 1};
        vt[1]  = '{1'b1, B, 1'b0, 32'h12, 32'h0000_00AA, 1'b0, 32'h0, 1'b0, 1'b0, 2};
        vt[2]  = '{1'b0, W, 1'b0, 32'h10, 32'h0, 1'b1, 32'h11AA_3344, 1'b0, 1'b1, 1};
        vt[3]  = '{1'b0, B, 1'b1, 32'h12, 32'h0, 1'b1, 32'hFFFF_FFAA, 1'b0, 1'b1, 1};
        vt[4]  = '{1'b0, H, 1'b0, 32'h12, 32'h0, 1'b1, 32'h0000_11AA, 1'b0, 1'b1, 1};
        vt[5]  = '{1'b0, H, 1'b1, 32'h10, 32'h0, 1'b1, 32'h0000_3344, 1'b0, 1'b1, 1};
        vt[6]  = '{1'b0, W, 1'b0, 32'h3,  32'h0, 1'b1, 32'h0, 1'b1, 1'b1, 0};
        vt[7]  = '{1'b1, H, 1'b0, 32'h11, 32'h5555, 1'b0, 32'h0, 1'b1, 1'b0, 0};
        vt[8]  = '{1'b0, X, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1, 0};
        vt[9]  = '{1'b1, W, 1'b0, MB, 32'h0000_1FFF, 1'b0, 32'h0, 1'b0, 1'b0, 1};
        vt[10] = '{1'b1, W, 1'b0, 32'h2_0000, 32'h1234_5678, 1'b0, 32'h0, 1'b1, 1'b0, 0};
        vt[11] = '{1'b0, W, 1'b0, MB, 32'h0, 1'b1, 32'h0000_1FFF, 1'b0, 1'b1, 1};
        vt[12] = '{1'b0, B, 1'b0, MB, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1, 0};
        vt[13] = '{1'b0, W, 1'b0, MB + 32'd12, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1, 0};
        vt[14] = '{1'b1, W, 1'b0, 32'h7FFC, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0, 1'b0, 1};
        vt[15] = '{1'b0, B, 1'b0, 32'h7FFF, 32'h0, 1'b1, 32'h0000_00CA, 1'b0, 1'b1, 1};
        vt[16] = '{1'b0, W, 1'b0, 32'h8000, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1, 0};
        vt[17] = '{1'b1, H, 1'b0, 32'h16, 32'h1234_BEEF, 1'b0, 32'h0, 1'b0, 1'b0, 2};
        vt[18] = '{1'b0, H, 1'b1, 32'h16, 32'h0, 1'b1, 32'hFFFF_BEEF, 1'b0, 1'b1, 1};

        // Reset held for three cycles, then INIT -> IDLE
        resetN = 1'b0; memExecute = 1'b0; memWrite = 1'b0; memSize = 2'b00;
        memSign = 1'b0; memAddress = 32'd0; inputData = 32'd0;
        repeat (3) @(negedge clk);
        check("reset memReady", 32'(memReady), 32'd0);
        check("reset dataReady", 32'(dataReady), 32'd0);
        check("reset memFault", 32'(memFault), 32'd0);
        check("reset outputData", outputData, 32'd0);
        check("reset display", {20'd0, sevenSegEn, sevenSeg}, {31'd0, leds}); // all zero
        check("reset leds", 32'(leds), 32'd0);
        check("reset timerIrq", 32'(timerIrq), 32'd0);
        resetN = 1'b1;
        @(negedge clk);
        check("memReady after INIT", 32'(memReady), 32'd1);

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            do_op(vt[i].wr, vt[i].sz, vt[i].sg, vt[i].addr, vt[i].data, rd, fl, dr, lat);
            check($sformatf("vec%0d memFault", i), 32'(fl), 32'(vt[i].exp_flt));
            check($sformatf("vec%0d dataReady", i), 32'(dr), 32'(vt[i].exp_dr));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vt[i].exp_lat));
            if (vt[i].chk_data) begin
                check($sformatf("vec%0d outputData", i), rd, vt[i].exp_data);
            end
        end
        check("leds", 32'(leds), 32'd1);
        check("sevenSeg", 32'(sevenSeg), 32'h0000_00FF);
        check("sevenSegEn", 32'(sevenSegEn), 32'h0000_000F);

        // Timer: compare = 10, counter reloaded to 0, irq rises 11-12 cycles later
        do_op(1'b1, W, 1'b0, MB + 32'd8, 32'd10, rd, fl, dr, lat);
        do_op(1'b1, W, 1'b0, MB + 32'd4, 32'd0, rd, fl, dr, lat);
        @(negedge clk);
        check("irq low after counter reload", 32'(timerIrq), 32'd0);
        n = 1;
        while (timerIrq !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("irq rise delay %0d in 11..12", n), 32'((n >= 11) && (n <= 12)), 32'd1);

        // Timer wrap with compare = 0: irq stays high across the wrap
        do_op(1'b1, W, 1'b0, MB + 32'd8, 32'd0, rd, fl, dr, lat);
        do_op(1'b1, W, 1'b0, MB + 32'd4, 32'hFFFF_FFFF, rd, fl, dr, lat);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("irq high across wrap %0d", i), 32'(timerIrq), 32'd1);
        end
        do_op(1'b0, W, 1'b0, MB + 32'd4, 32'd0, rd, fl, dr, lat);
        check($sformatf("counter wrapped small (%08h)", rd), 32'(rd < 32'd32), 32'd1);
        check("irq high after wrap", 32'(timerIrq), 32'd1);

        // Randomized traffic over the first 256 bytes against a byte model
        for (int i = 0; i < 64; i++) begin
            rdt = $urandom;
            do_op(1'b1, W, 1'b0, 32'(i * 4), rdt, rd, fl, dr, lat);
            for (int b = 0; b < 4; b++) ref_mem[i * 4 + b] = 8'(rdt >> (8 * b));
            check($sformatf("fill %0d fault", i), 32'(fl), 32'd0);
        end
        for (int i = 0; i < 200; i++) begin
            oor = ($urandom_range(0, 9) == 0);
            ra  = oor ? (32'h8000 + ($urandom & 32'h7FFF)) : ($urandom & 32'hFF);
            sz  = 2'($urandom_range(0, 3));
            sg  = 1'($urandom);
            wr  = 1'($urandom);
            rdt = $urandom;
            ef  = oor || (sz == X) || (sz == H && ra[0]) || (sz == W && ra[1:0] != 2'b00);
            nb  = 1 << sz;
            do_op(wr, sz, sg, ra, rdt, rd, fl, dr, lat);
            check($sformatf("rnd%0d memFault a=%08h", i, ra), 32'(fl), 32'(ef));
            if (ef) begin
                el = 0;
                check($sformatf("rnd%0d dataReady", i), 32'(dr), 32'(!wr));
                if (!wr) check($sformatf("rnd%0d fault data", i), rd, 32'd0);
            end else if (wr) begin
                el = (nb == 4) ? 1 : 2;
                for (int b = 0; b < nb; b++) ref_mem[int'(ra[7:0]) + b] = 8'(rdt >> (8 * b));
                check($sformatf("rnd%0d dataReady", i), 32'(dr), 32'd0);
            end else begin
                el = 1;
                ev = 32'd0;
                for (int b = 0; b < nb; b++) ev = ev | (32'(ref_mem[int'(ra[7:0]) + b]) << (8 * b));
                if (sg && nb < 4 && ev[8 * nb - 1]) ev = ev | ~((32'd1 << (8 * nb)) - 32'd1);
                check($sformatf("rnd%0d dataReady", i), 32'(dr), 32'd1);
                check($sformatf("rnd%0d load a=%08h sz=%0d sg=%0d", i, ra, sz, sg), rd, ev);
            end
            check($sformatf("rnd%0d latency", i), 32'(lat), 32'(el));
        end

        // Reset asserted while a word store sits in WR: RAM keeps its old word
        do_op(1'b1, W, 1'b0, 32'h40, 32'h1234_5678, rd, fl, dr, lat);
        memExecute = 1'b1; memWrite = 1'b1; memSize = W; memSign = 1'b0;
        memAddress = 32'h40; inputData = 32'hDEAD_BEEF;
        @(negedge clk);
        memExecute = 1'b0;
        check("in WR memReady low", 32'(memReady), 32'd0);
        resetN = 1'b0;
        repeat (2) @(negedge clk);
        check("mid-store reset memReady", 32'(memReady), 32'd0);
        check("mid-store reset leds", 32'(leds), 32'd0);
        check("mid-store reset timerIrq", 32'(timerIrq), 32'd0);
        resetN = 1'b1;
        @(negedge clk);
        check("memReady after second reset", 32'(memReady), 32'd1);
        do_op(1'b0, W, 1'b0, 32'h40, 32'd0, rd, fl, dr, lat);
        check("word unchanged after mid-store reset", rd, 32'h1234_5678);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
